// File: rtl/toast_mem_stage.sv
// Memory stage of the pipeline: issues one data-bus transaction per load/store, stalls upstream
// until the response arrives, and registers writeback controls and extended load data.
module toast_mem_stage (
   input  logic        clk_i,
   input  logic        resetn_i,
   input  logic        EX_mem_wr_en_i,
   input  logic        EX_mem_rd_en_i,
   input  logic [3:0]  EX_mem_op_i,
   input  logic [31:0] EX_rs2_data_i,
   input  logic [31:0] EX_alu_result_i,
   input  logic        EX_memtoreg_i,
   input  logic        EX_rd_wr_en_i,
   input  logic [4:0]  EX_rd_addr_i,
   input  logic        EX_exception_i,
   output logic        D_req_o,
   output logic        D_we_o,
   output logic [31:0] D_addr_o,
   output logic [3:0]  D_be_o,
   output logic [31:0] D_wdata_o,
   input  logic        D_gnt_i,
   input  logic        D_rvalid_i,
   input  logic [31:0] D_rdata_i,
   output logic        MEM_stall_o,
   output logic        MEM_rd_wr_en_o,
   output logic        MEM_memtoreg_o,
   output logic [4:0]  MEM_rd_addr_o,
   output logic [31:0] MEM_alu_result_o,
   output logic [31:0] MEM_rd_data_o,
   output logic        MEM_exception_o
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

   state_e      state_q, state_d;
   logic [2:0]  funct3;
   logic [1:0]  byte_off;
   logic        access, op_ok, align_ok, legal, exc;
   logic        req_int, stall_int, load_done;
   logic [31:0] lane, ext_data;
   logic        unused_op_bit;

   logic        rd_wr_en_q, memtoreg_q, exception_q;
   logic [4:0]  rd_addr_q;
   logic [31:0] alu_result_q, rd_data_q, rd_data_d;

   assign funct3        = EX_mem_op_i[2:0];
   assign byte_off      = EX_alu_result_i[1:0];
   assign unused_op_bit = EX_mem_op_i[3];

   always_comb begin
      access = EX_mem_rd_en_i | EX_mem_wr_en_i;
      if (EX_mem_rd_en_i)
         op_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b101);
      else
         op_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      case (funct3[1:0])
         2'b01:   align_ok = ~byte_off[0];
         2'b10:   align_ok = (byte_off == 2'b00);
         default: align_ok = 1'b1;
      endcase
      legal = (EX_mem_rd_en_i ^ EX_mem_wr_en_i) & ~EX_exception_i & op_ok & align_ok;
      exc   = (access & ~legal) | EX_exception_i;
   end

   // Bus address, enables and write data depend only on the (held-stable) EX inputs.
   assign D_addr_o = {EX_alu_result_i[31:2], 2'b00};
   assign D_we_o   = EX_mem_wr_en_i;

   always_comb begin
      case (funct3[1:0])
         2'b00: begin
            D_be_o    = 4'b0001 << byte_off;
            D_wdata_o = {4{EX_rs2_data_i[7:0]}};
         end
         2'b01: begin
            D_be_o    = byte_off[1] ? 4'b1100 : 4'b0011;
            D_wdata_o = {2{EX_rs2_data_i[15:0]}};
         end
         default: begin
            D_be_o    = 4'b1111;
            D_wdata_o = EX_rs2_data_i;
         end
      endcase
   end

   always_comb begin
      lane = D_rdata_i >> {byte_off, 3'b000};
      case (funct3)
         3'b000:  ext_data = {{24{lane[7]}}, lane[7:0]};
         3'b001:  ext_data = {{16{lane[15]}}, lane[15:0]};
         3'b100:  ext_data = {24'd0, lane[7:0]};
         3'b101:  ext_data = {16'd0, lane[15:0]};
         default: ext_data = lane;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      req_int   = 1'b0;
      stall_int = 1'b0;
      case (state_q)
         IDLE: begin
            if (access && legal) begin
               req_int   = 1'b1;
               stall_int = 1'b1;
               state_d   = D_gnt_i ? RESP : REQ;
            end
         end
         REQ: begin
            req_int   = 1'b1;
            stall_int = 1'b1;
            if (D_gnt_i) state_d = RESP;
         end
         RESP: begin
            stall_int = ~D_rvalid_i;
            if (D_rvalid_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Reset must silence the bus and release the pipeline without waiting for a clock.
   assign D_req_o     = req_int & resetn_i;
   assign MEM_stall_o = stall_int & resetn_i;

   assign load_done = (state_q == RESP) & D_rvalid_i & EX_mem_rd_en_i;
   assign rd_data_d = load_done ? ext_data : rd_data_q;

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q      <= IDLE;
         rd_wr_en_q   <= 1'b0;
         memtoreg_q   <= 1'b0;
         exception_q  <= 1'b0;
         rd_addr_q    <= 5'd0;
         alu_result_q <= 32'd0;
         rd_data_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         if (!stall_int) begin
            rd_wr_en_q   <= EX_rd_wr_en_i & ~exc;
            memtoreg_q   <= EX_memtoreg_i;
            exception_q  <= exc;
            rd_addr_q    <= EX_rd_addr_i;
            alu_result_q <= EX_alu_result_i;
            rd_data_q    <= rd_data_d;
         end
      end
   end

   assign MEM_rd_wr_en_o   = rd_wr_en_q;
   assign MEM_memtoreg_o   = memtoreg_q;
   assign MEM_exception_o  = exception_q;
   assign MEM_rd_addr_o    = rd_addr_q;
   assign MEM_alu_result_o = alu_result_q;
   assign MEM_rd_data_o    = rd_data_q;

endmodule

// File: doc/toast_mem_stage.md
TOAST_MEM_STAGE -- requirements
Module: toast_mem_stage

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
- clk_i  in  1  sole clock, rising edge
- resetn_i  in  1  reset, asynchronous, active-low
- EX_mem_wr_en_i  in  1  store request
- EX_mem_rd_en_i  in  1  load request
- EX_mem_op_i  in  4  [2:0] = RV32I funct3, [3] ignored
- EX_rs2_data_i  in  32  store data
- EX_alu_result_i  in  32  byte address / ALU result
- EX_memtoreg_i, EX_rd_wr_en_i  in  1 each  writeback control
- EX_rd_addr_i  in  5  destination register
- EX_exception_i  in  1  upstream exception
- D_req_o  out  1  bus request
- D_we_o  out  1  1 = write
- D_addr_o  out  32  word address, {EX_alu_result_i[31:2],2'b00}
- D_be_o  out  4  byte enables
- D_wdata_o  out  32  lane-replicated store data
- D_gnt_i  in  1  request accepted
- D_rvalid_i  in  1  response valid (loads and stores)
- D_rdata_i  in  32  read word
- MEM_stall_o  out  1  freeze upstream stages
- MEM_rd_wr_en_o, MEM_memtoreg_o  out  1 each  registered controls
- MEM_rd_addr_o  out  5  registered destination
- MEM_alu_result_o  out  32  registered ALU result
- MEM_rd_data_o  out  32  registered extended load data
- MEM_exception_o  out  1  registered exception
REQ-002 Upstream SHALL hold all EX_* inputs stable while MEM_stall_o=1; D_addr_o/D_we_o/D_be_o/D_wdata_o are combinational from EX_* inputs.

Function
REQ-003 Access = EX_mem_rd_en_i|EX_mem_wr_en_i; legal = exactly one set, EX_exception_i=0, op[2:0] in {000,001,010,100,101} (load) or {000,001,010} (store), aligned (halfword: addr[0]=0; word: addr[1:0]=0).
REQ-004 FSM states IDLE, REQ, RESP.
REQ-005 IDLE: legal access -> D_req_o=1, MEM_stall_o=1; D_gnt_i=1 -> RESP, else -> REQ. No/illegal access -> D_req_o=0, MEM_stall_o=0, stay IDLE.
REQ-006 REQ: D_req_o=1, MEM_stall_o=1; D_gnt_i=1 -> RESP.
REQ-007 RESP: D_req_o=0; MEM_stall_o = ~D_rvalid_i; D_rvalid_i=1 -> IDLE.
REQ-008 D_rvalid_i SHALL be ignored in IDLE and REQ; D_gnt_i ignored outside IDLE/REQ.
REQ-009 Output registers SHALL load on each rising edge with MEM_stall_o=0: rd_addr, memtoreg, alu_result from EX_*; rd_wr_en = EX_rd_wr_en_i & ~exc; MEM_exception_o = exc; MEM_rd_data_o = extended load data when a load completes, else unchanged. exc = access & ~legal, or EX_exception_i.
REQ-010 While MEM_stall_o=1 output registers SHALL hold.
REQ-011 D_be_o: byte = 4'b0001<<addr[1:0]; half = addr[1]?1100:0011; word = 1111; loads use same enables.
REQ-012 D_wdata_o: SB {4{rs2[7:0]}}, SH {2{rs2[15:0]}}, SW rs2.
REQ-013 Load data: lane = D_rdata_i >> (8*addr[1:0]); LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-014 Latency: non-memory op 1 cycle; access with gnt in first cycle and rvalid next cycle = 2 cycles (1 stall cycle); each extra gnt/rvalid wait cycle adds 1.
REQ-015 Illegal access SHALL never assert D_req_o and SHALL not stall.

Reset
REQ-016 resetn_i=0 SHALL immediately force IDLE, D_req_o=0, MEM_stall_o=0, all MEM_* outputs 0, including mid-transaction; a late D_rvalid_i after reset is ignored.

Verification
REQ-017 ALU op, rd=5, alu_result=0x1234 -> next edge MEM_rd_wr_en_o=1, MEM_alu_result_o=0x1234, no D_req_o, no stall.
REQ-018 LB addr=0x103, D_rdata_i=0x80FF_1122 returned with gnt same cycle, rvalid next -> D_addr_o=0x100, D_be_o=1000, one stall cycle, MEM_rd_data_o=0xFFFFFF80.
REQ-019 SH addr=0x202, rs2=0xABCD_5678, gnt delayed 2 cycles -> D_we_o=1, D_be_o=1100, D_wdata_o=0x5678_5678, MEM_stall_o high 3 cycles then until rvalid.
REQ-020 LW addr=0x101 -> no D_req_o, no stall, MEM_exception_o=1, MEM_rd_wr_en_o=0.
REQ-021 LHU addr=0x002, rdata=0x9ABC_0000 -> MEM_rd_data_o=0x0000_9ABC.
REQ-022 resetn_i low in RESP -> D_req_o/MEM_stall_o 0 at once, outputs 0; subsequent rvalid pulse in IDLE changes nothing.
